// File: rtl/vis_wb_responder_pkg.sv
// Shared register map, status/control bit positions and sizing helper for
// the visibility Wishbone responder.
package vis_wb_responder_pkg;

    localparam logic [15:0] VIS_REG_STATUS = 16'h0000;
    localparam logic [15:0] VIS_REG_DATA   = 16'h0001;
    localparam logic [15:0] VIS_REG_CTRL   = 16'h0002;
    localparam logic [15:0] VIS_REG_FRAMES = 16'h0003;

    localparam int ST_AVAIL    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_TLAST    = 2;
    localparam int ST_UNDERRUN = 3;

    localparam int CTRL_CLR_UNDERRUN = 0;
    localparam int CTRL_FLUSH        = 1;

    // Bytes needed to serialise one (re, im) pair.
    function automatic int bytes_per_entry(input int data_bits);
        return 2 * (data_bits / 8);
    endfunction

endpackage

// File: rtl/vis_pair_fifo.sv
// Small synchronous FIFO holding {tlast, im, re} visibility entries.
// Flush empties it in one cycle and discards a push arriving in that cycle.
module vis_pair_fifo #(
    parameter int WIDTH = 65,
    parameter int ABITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [ABITS:0]   count,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 2 ** ABITS;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ABITS-1:0] wr_ptr;
    logic [ABITS-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (ABITS + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointer and occupancy bookkeeping; flush wins over everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage has no reset; the count/pointers alone define which entries are valid.
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vis_wb_responder.sv
// Wishbone classic 8-bit slave serving buffered correlator visibility pairs
// byte by byte, with STATUS, DATA, CONTROL and FRAMES registers.
module vis_wb_responder
    import vis_wb_responder_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int ABITS     = 1,
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] adr_i,
    input  logic [7:0]           dat_i,
    output logic [7:0]           dat_o,
    output logic                 ack_o,
    output logic                 rty_o,
    output logic                 err_o,
    input  logic                 s_tvalid_i,
    output logic                 s_tready_o,
    input  logic                 s_tlast_i,
    input  logic [DATA_BITS-1:0] s_revis_i,
    input  logic [DATA_BITS-1:0] s_imvis_i,
    output logic                 frame_o
);

    localparam int BPE        = bytes_per_entry(DATA_BITS);
    localparam int IDX_BITS   = $clog2(BPE);
    localparam int ENTRY_BITS = 2 * DATA_BITS + 1;
    localparam int DEPTH      = 2 ** ABITS;

    logic [ENTRY_BITS-1:0]  head;
    logic [ABITS:0]         count;
    logic                   full;
    logic                   empty;
    logic [IDX_BITS-1:0]    byte_idx;
    logic                   underrun;
    logic [7:0]             frames;
    logic [2*DATA_BITS-1:0] pair_bits;
    logic [7:0]             head_byte;
    logic [7:0]             status;
    logic                   head_tlast;
    logic                   last_byte;
    logic                   req;
    logic                   is_status, is_data, is_ctrl, is_frames;
    logic                   data_rd_ok, data_rd_empty, ctrl_wr;
    logic                   push, pop, flush, clr_underrun;

    assign s_tready_o = ~rst_i & (count != (ABITS + 1)'(DEPTH));
    assign push       = s_tvalid_i & s_tready_o;

    vis_pair_fifo #(
        .WIDTH(ENTRY_BITS),
        .ABITS(ABITS)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({s_tlast_i, s_imvis_i, s_revis_i}),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Request decode, byte selection and side-effect strobes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        req           = cyc_i & stb_i & ~(ack_o | rty_o | err_o);
        is_status     = (adr_i == ADDR_BITS'(VIS_REG_STATUS));
        is_data       = (adr_i == ADDR_BITS'(VIS_REG_DATA));
        is_ctrl       = (adr_i == ADDR_BITS'(VIS_REG_CTRL));
        is_frames     = (adr_i == ADDR_BITS'(VIS_REG_FRAMES));
        head_tlast    = head[ENTRY_BITS-1];
        pair_bits     = {head[DATA_BITS-1:0], head[2*DATA_BITS-1:DATA_BITS]};
        head_byte     = pair_bits[8*(BPE-1-32'(byte_idx)) +: 8];
        last_byte     = (byte_idx == IDX_BITS'(BPE - 1));
        data_rd_ok    = req & is_data & ~we_i & ~empty;
        data_rd_empty = req & is_data & ~we_i & empty;
        ctrl_wr       = req & is_ctrl & we_i;
        pop           = data_rd_ok & last_byte;
        flush         = ctrl_wr & dat_i[CTRL_FLUSH];
        clr_underrun  = ctrl_wr & dat_i[CTRL_CLR_UNDERRUN];
        status               = '0;
        status[ST_AVAIL]     = ~empty;
        status[ST_FULL]      = full;
        status[ST_TLAST]     = ~empty & head_tlast;
        status[ST_UNDERRUN]  = underrun;
    end

    // Registered single-cycle Wishbone response and read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o   <= 1'b0;
            rty_o   <= 1'b0;
            err_o   <= 1'b0;
            frame_o <= 1'b0;
            dat_o   <= '0;
        end else begin
            ack_o   <= 1'b0;
            rty_o   <= 1'b0;
            err_o   <= 1'b0;
            frame_o <= 1'b0;
            if (req) begin
                if (is_data && !we_i) begin
                    if (!empty) begin
                        ack_o   <= 1'b1;
                        dat_o   <= head_byte;
                        frame_o <= last_byte & head_tlast;
                    end else begin
                        rty_o <= 1'b1;
                    end
                end else if (is_ctrl) begin
                    ack_o <= 1'b1;
                    if (!we_i) dat_o <= 8'h00;
                end else if ((is_status || is_frames) && !we_i) begin
                    ack_o <= 1'b1;
                    dat_o <= is_status ? status : frames;
                end else begin
                    err_o <= 1'b1;
                end
            end
        end
    end

    // Byte serialiser position, underrun flag and frame counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_idx <= '0;
            underrun <= 1'b0;
            frames   <= '0;
        end else begin
            if (flush)           byte_idx <= '0;
            else if (data_rd_ok) byte_idx <= last_byte ? '0 : byte_idx + 1'b1;

            if (flush || clr_underrun) underrun <= 1'b0;
            else if (data_rd_empty)    underrun <= 1'b1;

            if (pop && head_tlast) frames <= frames + 8'd1;
        end
    end

endmodule

// File: tb/tb_vis_wb_responder.sv
// Directed bench for vis_wb_responder: register map, byte serialisation,
// backpressure, frame counting, flush, error/retry responses and reset.
module tb_vis_wb_responder;
    import vis_wb_responder_pkg::*;

    localparam int DATA_BITS = 32;
    localparam int ABITS     = 1;
    localparam int ADDR_BITS = 16;
    localparam logic [2:0] R_ACK = 3'b100;
    localparam logic [2:0] R_RTY = 3'b010;
    localparam logic [2:0] R_ERR = 3'b001;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 cyc_i, stb_i, we_i;
    logic [ADDR_BITS-1:0] adr_i;
    logic [7:0]           dat_i;
    logic [7:0]           dat_o;
    logic                 ack_o, rty_o, err_o;
    logic                 s_tvalid_i, s_tready_o, s_tlast_i;
    logic [DATA_BITS-1:0] s_revis_i, s_imvis_i;
    logic                 frame_o;

    int vectors    = 0;
    int miscompares = 0;

    logic [2:0] resp;
    logic [7:0] rd;
    logic       frm;

    vis_wb_responder #(
        .DATA_BITS(DATA_BITS),
        .ABITS    (ABITS),
        .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cyc_i     (cyc_i),
        .stb_i     (stb_i),
        .we_i      (we_i),
        .adr_i     (adr_i),
        .dat_i     (dat_i),
        .dat_o     (dat_o),
        .ack_o     (ack_o),
        .rty_o     (rty_o),
        .err_o     (err_o),
        .s_tvalid_i(s_tvalid_i),
        .s_tready_o(s_tready_o),
        .s_tlast_i (s_tlast_i),
        .s_revis_i (s_revis_i),
        .s_imvis_i (s_imvis_i),
        .frame_o   (frame_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One Wishbone transfer; returns {ack,rty,err}, dat_o and frame_o from the response cycle.
    task automatic wb(input logic we, input logic [15:0] adr, input logic [7:0] wd,
                      output logic [2:0] r, output logic [7:0] d, output logic f);
        int n = 0;
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd;
        do begin
            @(posedge clk_i); #1;
            n++;
        end while (!(ack_o | rty_o | err_o) && n < 4);
        r = {ack_o, rty_o, err_o};
        d = dat_o;
        f = frame_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic push(input logic [31:0] re, input logic [31:0] im, input logic last);
        int n = 0;
        @(negedge clk_i);
        s_tvalid_i = 1'b1; s_revis_i = re; s_imvis_i = im; s_tlast_i = last;
        while (!s_tready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("push ready", 32'(s_tready_o), 32'd1);
        @(posedge clk_i); #1;
        s_tvalid_i = 1'b0;
    endtask

    task automatic reg_read(input string tag, input logic [15:0] adr, input logic [7:0] exp);
        logic [2:0] r; logic [7:0] d; logic f;
        wb(1'b0, adr, 8'h00, r, d, f);
        check({tag, " resp"}, 32'(r), 32'(R_ACK));
        check({tag, " data"}, 32'(d), 32'(exp));
    endtask

    task automatic read8(input string tag, input logic [31:0] re, input logic [31:0] im, input logic last);
        logic [63:0] both;
        logic [2:0]  r; logic [7:0] d; logic f;
        both = {re, im};
        for (int k = 0; k < 8; k++) begin
            wb(1'b0, VIS_REG_DATA, 8'h00, r, d, f);
            check($sformatf("%s b%0d resp", tag, k), 32'(r), 32'(R_ACK));
            check($sformatf("%s b%0d data", tag, k), 32'(d), 32'(both[63-8*k -: 8]));
            check($sformatf("%s b%0d frame", tag, k), 32'(f), 32'((k == 7) && last));
        end
    endtask

    initial begin
        rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0;
        s_tvalid_i = 1'b0; s_tlast_i = 1'b0; s_revis_i = '0; s_imvis_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst ack", 32'(ack_o), 32'd0);
        check("rst rty", 32'(rty_o), 32'd0);
        check("rst err", 32'(err_o), 32'd0);
        check("rst dat", 32'(dat_o), 32'd0);
        check("rst frame", 32'(frame_o), 32'd0);
        @(negedge clk_i); rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("rst tready", 32'(s_tready_o), 32'd1);
        reg_read("rst status", VIS_REG_STATUS, 8'h00);
        reg_read("rst frames", VIS_REG_FRAMES, 8'h00);

        // Basic pair serialisation.
        push(32'h11223344, 32'h55667788, 1'b0);
        reg_read("one status", VIS_REG_STATUS, 8'h01);
        read8("pairA", 32'h11223344, 32'h55667788, 1'b0);
        reg_read("drained status", VIS_REG_STATUS, 8'h00);
        check("drained tready", 32'(s_tready_o), 32'd1);

        // Underrun retry and clear.
        wb(1'b0, VIS_REG_DATA, 8'h00, resp, rd, frm);
        check("empty rd resp", 32'(resp), 32'(R_RTY));
        reg_read("underrun status", VIS_REG_STATUS, 8'h08);
        wb(1'b1, VIS_REG_CTRL, 8'h01, resp, rd, frm);
        check("clr ctrl resp", 32'(resp), 32'(R_ACK));
        reg_read("cleared status", VIS_REG_STATUS, 8'h00);

        // Backpressure: three pairs with valid held high.
        @(negedge clk_i);
        s_tvalid_i = 1'b1; s_tlast_i = 1'b0; s_revis_i = 32'hA0A1A2A3; s_imvis_i = 32'hA4A5A6A7;
        @(posedge clk_i); #1;
        s_revis_i = 32'hB0B1B2B3; s_imvis_i = 32'hB4B5B6B7;
        @(posedge clk_i); #1;
        s_revis_i = 32'hC0C1C2C3; s_imvis_i = 32'hC4C5C6C7; s_tlast_i = 1'b1;
        check("full tready", 32'(s_tready_o), 32'd0);
        reg_read("full status", VIS_REG_STATUS, 8'h03);
        read8("pairA2", 32'hA0A1A2A3, 32'hA4A5A6A7, 1'b0);
        check("after pop tready", 32'(s_tready_o), 32'd1);
        @(posedge clk_i); #1;
        check("third accepted tready", 32'(s_tready_o), 32'd0);
        s_tvalid_i = 1'b0;
        read8("pairB", 32'hB0B1B2B3, 32'hB4B5B6B7, 1'b0);
        reg_read("tlast head status", VIS_REG_STATUS, 8'h05);
        read8("pairC", 32'hC0C1C2C3, 32'hC4C5C6C7, 1'b1);
        reg_read("frames one", VIS_REG_FRAMES, 8'h01);

        // Frame counter wrap.
        for (int i = 0; i < 254; i++) begin
            push(32'(i), 32'hF00D0000 | 32'(i), 1'b1);
            read8("wrap", 32'(i), 32'hF00D0000 | 32'(i), 1'b1);
        end
        reg_read("frames 255", VIS_REG_FRAMES, 8'hFF);
        push(32'h01020304, 32'h05060708, 1'b1);
        read8("wrap last", 32'h01020304, 32'h05060708, 1'b1);
        reg_read("frames wrap", VIS_REG_FRAMES, 8'h00);

        // Flush mid-entry with a simultaneous push.
        push(32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
        for (int k = 0; k < 3; k++) begin
            wb(1'b0, VIS_REG_DATA, 8'h00, resp, rd, frm);
            check($sformatf("partial b%0d resp", k), 32'(resp), 32'(R_ACK));
        end
        check("partial b2 data", 32'(rd), 32'hBE);
        s_tvalid_i = 1'b1; s_revis_i = 32'h99999999; s_imvis_i = 32'h88888888; s_tlast_i = 1'b0;
        wb(1'b1, VIS_REG_CTRL, 8'h02, resp, rd, frm);
        s_tvalid_i = 1'b0;
        check("flush resp", 32'(resp), 32'(R_ACK));
        check("flush tready", 32'(s_tready_o), 32'd1);
        reg_read("flushed status", VIS_REG_STATUS, 8'h00);
        wb(1'b0, VIS_REG_DATA, 8'h00, resp, rd, frm);
        check("flushed rd resp", 32'(resp), 32'(R_RTY));
        wb(1'b1, VIS_REG_CTRL, 8'h03, resp, rd, frm);
        check("flush+clr resp", 32'(resp), 32'(R_ACK));
        reg_read("flush clears underrun", VIS_REG_STATUS, 8'h00);
        push(32'h12345678, 32'h9ABCDEF0, 1'b0);
        read8("post flush", 32'h12345678, 32'h9ABCDEF0, 1'b0);

        // Error responses and retry keeping dat_o.
        wb(1'b0, 16'h0004, 8'h00, resp, rd, frm);
        check("unmapped resp", 32'(resp), 32'(R_ERR));
        wb(1'b0, 16'h0100, 8'h00, resp, rd, frm);
        check("high addr resp", 32'(resp), 32'(R_ERR));
        reg_read("ctrl read", VIS_REG_CTRL, 8'h00);
        push(32'h0F1E2D3C, 32'h4B5A6978, 1'b0);
        wb(1'b1, VIS_REG_DATA, 8'h5A, resp, rd, frm);
        check("wr data resp", 32'(resp), 32'(R_ERR));
        wb(1'b1, VIS_REG_STATUS, 8'h02, resp, rd, frm);
        check("wr status resp", 32'(resp), 32'(R_ERR));
        wb(1'b1, VIS_REG_FRAMES, 8'h00, resp, rd, frm);
        check("wr frames resp", 32'(resp), 32'(R_ERR));
        reg_read("no pop status", VIS_REG_STATUS, 8'h01);
        read8("after err", 32'h0F1E2D3C, 32'h4B5A6978, 1'b0);
        wb(1'b0, VIS_REG_DATA, 8'h00, resp, rd, frm);
        check("retry resp", 32'(resp), 32'(R_RTY));
        check("retry dat hold", 32'(rd), 32'h78);

        // Reset between request and response.
        push(32'h11111111, 32'h22222222, 1'b1);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = VIS_REG_DATA;
        #2 rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("midrst ack", 32'(ack_o), 32'd0);
        check("midrst rty", 32'(rty_o), 32'd0);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(negedge clk_i); rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("postrst ack", 32'(ack_o), 32'd0);
        check("postrst err", 32'(err_o), 32'd0);
        check("postrst dat", 32'(dat_o), 32'd0);
        check("postrst frame", 32'(frame_o), 32'd0);
        check("postrst tready", 32'(s_tready_o), 32'd1);
        reg_read("postrst status", VIS_REG_STATUS, 8'h00);
        reg_read("postrst frames", VIS_REG_FRAMES, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vis_wb_responder.md
Name: vis_wb_responder

Overview:
- Wishbone classic slave (8-bit data) that serves correlator visibility words to the SPI-to-Wishbone bridge.
- It is the responder for the bridge's initiator cycles.
- It accepts a valid/ready stream of (real, imaginary) visibility pairs from the correlator bus port and buffers them in a small FIFO.
- It serialises each buffered pair into bytes on reads of a data port, and also exposes status, control and frame-count registers.

Parameters:
- DATA_BITS, 32, width of each real/imag visibility component; must be a multiple of 8.
- ABITS, 1, log2 of FIFO depth in entries (default depth 2).
- ADDR_BITS, 16, Wishbone address width.

Ports:
- clk_i  in  1  bus clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cyc_i  in  1  Wishbone cycle.
- stb_i  in  1  Wishbone strobe.
- we_i  in  1  write enable.
- adr_i  in  ADDR_BITS  register address.
- dat_i  in  8  write data.
- dat_o  out  8  read data.
- ack_o  out  1  transfer acknowledge.
- rty_o  out  1  retry (data port read while empty).
- err_o  out  1  error (unmapped address, or write to read-only register).
- s_tvalid_i  in  1  visibility pair valid.
- s_tready_o  out  1  FIFO can accept a pair.
- s_tlast_i  in  1  last pair of a visibility frame.
- s_revis_i  in  DATA_BITS  real component.
- s_imvis_i  in  DATA_BITS  imaginary component.
- frame_o  out  1  one-cycle pulse when the final byte of a tlast entry is read.

Behaviour:
- Reset: all outputs 0 except s_tready_o, which is 1 once reset is released (FIFO empty). FIFO count, byte index, sticky flags and frame counter are all 0.
- Register map (adr_i compared in full):
  - 0x0000 STATUS, read-only:
    - bit0 = entry available.
    - bit1 = FIFO full.
    - bit2 = head entry tlast.
    - bit3 = underrun sticky.
    - bits7:4 = 0.
  - 0x0001 DATA, read-only: stream port.
  - 0x0002 CONTROL, write-only:
    - bit0 = clear underrun.
    - bit1 = flush.
    - Reads of 0x0002 return 0x00 with ack.
  - 0x0003 FRAMES, read-only: 8-bit count of completed frames; wraps 255 -> 0.
- Handshake:
  - A request is cyc_i & stb_i & ~(ack_o | rty_o | err_o).
  - Exactly one of ack_o / rty_o / err_o is asserted, registered, the cycle after the request and for one cycle only. Latency is 1, so a transfer takes 2 cycles minimum.
  - dat_o is valid in the ack cycle and holds its value until the next response.
  - Dropping cyc_i in the response cycle has no effect on internal state; the side effect has already been committed.
- Data port read, entry available:
  - Returns byte byte_idx of the head entry.
  - Byte order: re[DATA_BITS-1:DATA_BITS-8] ... re[7:0], then im MSB-first likewise; 2*DATA_BITS/8 bytes in total.
  - byte_idx increments.
  - On the final byte: head is popped, byte_idx returns to 0, and if the head tlast was set, frame_o pulses and FRAMES increments.
- Data port read, FIFO empty: rty_o is asserted, no pop, underrun is set, and dat_o is unchanged.
- Unmapped addresses, and writes to 0x0000, 0x0001 or 0x0003: err_o is asserted with no side effects.
- Stream input:
  - s_tready_o = (count != 2**ABITS), combinational from the registered count.
  - A push occurs on s_tvalid_i & s_tready_o.
  - A simultaneous push and pop leaves count unchanged. A push while full is impossible by construction.
- Flush (CONTROL write with bit1 set):
  - Count and byte_idx go to 0 and underrun is cleared; FRAMES is kept.
  - A push occurring in the flush cycle is discarded.
  - Flush has priority over clear-underrun; clear-underrun is implied by flush.
- Reset mid-transfer: all state returns to its reset values immediately. A subsequent ack for the interrupted request is not generated.

Decomposition:
- Shared package holds:
  - register address constants VIS_REG_STATUS, VIS_REG_DATA, VIS_REG_CTRL, VIS_REG_FRAMES;
  - STATUS/CONTROL bit-index constants;
  - a function returning bytes-per-entry from DATA_BITS.
- One natural sub-module, vis_pair_fifo:
  - synchronous FIFO of {tlast, im, re}, depth 2**ABITS;
  - provides push/pop, count, full/empty and head output;
  - flush input.
- The responder top holds the Wishbone response logic, the byte serialiser, the register file and the frame counter.

Test Plan:
- Push re=0x11223344, im=0x55667788, tlast=0, then issue 8 DATA reads -> acks with bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88. STATUS then reads 0x00 and s_tready_o=1.
- Read DATA with the FIFO empty -> rty_o, and STATUS reads 0x08. Write CONTROL=0x01 -> ack, and STATUS reads 0x00.
- Push 3 pairs with s_tvalid_i held high -> the third stalls with s_tready_o=0 and STATUS=0x03. Read 8 bytes -> the third pair is accepted the cycle after the pop.
- Push pair tlast=1, read 8 bytes -> frame_o pulses on the 8th ack cycle and FRAMES reads 0x01. Preload 255 frames -> FRAMES wraps to 0x00.
- Read 3 bytes of an entry, then write CONTROL=0x02 with a simultaneous push -> the FIFO is empty, STATUS=0x00, and the next DATA read returns rty_o.
- Read 0x0004 -> err_o. Write 0x0001 -> err_o with no pop. Assert rst_i between the request and the response -> no ack, and all outputs are at reset values.
